// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, condition codes, NZCV bit positions and
// the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check against NZCV; shared with the branch unit.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cond_sequencer.sv
// Issues one conditional instruction at a time to the shared ALU, waits for
// completion or timeout, commits NZCV and presents the result to writeback.
module alu_cond_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [3:0]  in_cond,
  input  logic        in_s_bit,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        alu_start,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_wr_en,
  output logic        out_err,
  output logic [3:0]  flags
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             cond_pass;

  cond_eval u_cond_eval (
    .cond  (in_cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // CMP always sets all four flags; ADD only with S; other ops clear C/V with S.
  function automatic logic [3:0] next_flags(
    input logic [3:0]  op,
    input logic        s,
    input logic [31:0] res,
    input logic        carry,
    input logic        ovf,
    input logic [3:0]  cur
  );
    logic [1:0] nz;
    nz = {res[31], (res == 32'd0)};
    if (op == OP_CMP || (s && op == OP_ADD)) return {nz, carry, ovf};
    else if (s)                              return {nz, 2'b00};
    else                                     return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      flags      <= 4'b0000;
      in_ready   <= 1'b1;
      alu_start  <= 1'b0;
      alu_opcode <= OP_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
      out_valid  <= 1'b0;
      out_wr_en  <= 1'b0;
      out_err    <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
      s_bit      <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_opcode <= in_opcode;
            alu_a      <= in_a;
            alu_b      <= in_b;
            s_bit      <= in_s_bit;
            in_ready   <= 1'b0;
            cnt        <= '0;
            if (!cond_pass || in_opcode == OP_NOP) begin
              state      <= ST_RESP;
              out_valid  <= 1'b1;
              out_wr_en  <= 1'b0;
              out_err    <= 1'b0;
              out_result <= '0;
            end else begin
              state     <= ST_WAIT;
              alu_start <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (alu_done) begin
            out_result <= alu_result;
            flags      <= next_flags(alu_opcode, s_bit, alu_result,
                                     alu_carry, alu_ovf, flags);
            out_wr_en  <= (alu_opcode != OP_CMP);
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            out_err   <= 1'b1;
            out_wr_en <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cond_sequencer.sv
// Directed bench for alu_cond_sequencer with a transaction-level model of
// condition evaluation, flag commit and response timing.
module tb_alu_cond_sequencer;
  import alu_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_cond;
  logic        in_s_bit;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        alu_start;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_wr_en;
  logic        out_err;
  logic [3:0]  flags;

  alu_cond_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_cond    (in_cond),
    .in_s_bit   (in_s_bit),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_start  (alu_start),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wr_en  (out_wr_en),
    .out_err    (out_err),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: conditions come in complementary pairs; odd codes invert the even one.
  function automatic logic model_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  function automatic logic [3:0] model_flags(input logic [3:0] op, input logic s,
                                             input logic [31:0] res, input logic c,
                                             input logic v, input logic [3:0] old);
    if (op == OP_CMP)          return {res[31], (res == 32'd0), c, v};
    if (!s)                    return old;
    if (op == OP_ADD)          return {res[31], (res == 32'd0), c, v};
    return {res[31], (res == 32'd0), 2'b00};
  endfunction

  logic [3:0]  e_flags, e_op;
  logic        e_ready, e_start, e_valid, e_wr, e_err, e_rchk;
  logic [31:0] e_result, e_a, e_b;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(e_ready));
      chk("alu_start", 32'(alu_start), 32'(e_start));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("flags",     32'(flags),     32'(e_flags));
      if (e_start) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(e_op));
        chk("alu_a", alu_a, e_a);
        chk("alu_b", alu_b, e_b);
      end
      if (e_valid) begin
        chk("out_err",   32'(out_err),   32'(e_err));
        chk("out_wr_en", 32'(out_wr_en), 32'(e_wr));
        if (e_rchk) chk("out_result", out_result, e_result);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d: cycles after the alu_start cycle at which alu_done is driven (-1: never).
  task automatic run_op(input logic [3:0] op, input logic [3:0] cond, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input int d,
                        input logic [31:0] res, input logic c, input logic v,
                        input int hold, input bit late);
    bit pass;
    in_valid = 1'b1; in_opcode = op; in_cond = cond; in_s_bit = s; in_a = a; in_b = b;
    pass = model_pass(cond, e_flags) && (op != OP_NOP);
    tick();
    in_valid = 1'b0;
    e_ready  = 1'b0;
    if (!pass) begin
      e_valid = 1'b1; e_wr = 1'b0; e_err = 1'b0; e_result = '0; e_rchk = 1'b1;
    end else begin
      e_start = 1'b1; e_op = op; e_a = a; e_b = b;
      for (int k = 0; k < TIMEOUT; k++) begin
        alu_done = (k == d); alu_result = res; alu_carry = c; alu_ovf = v;
        tick();
        e_start  = 1'b0;
        alu_done = 1'b0;
        if (k == d) begin
          e_flags = model_flags(op, s, res, c, v, e_flags);
          e_valid = 1'b1; e_wr = (op != OP_CMP); e_err = 1'b0;
          e_result = res; e_rchk = 1'b1;
          break;
        end
        if (k == TIMEOUT - 1) begin
          e_valid = 1'b1; e_wr = 1'b0; e_err = 1'b1; e_rchk = 1'b0;
        end
      end
    end
    for (int h = 0; h < hold; h++) begin
      alu_done = late && (h == 0);
      tick();
      alu_done = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    e_valid = 1'b0; e_err = 1'b0; e_ready = 1'b1;
  endtask

  task automatic expect_reset();
    e_flags = 4'b0000; e_ready = 1'b1; e_start = 1'b0; e_valid = 1'b0;
    e_wr = 1'b0; e_err = 1'b0; e_rchk = 1'b0; e_result = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; in_cond = 4'h0; in_s_bit = 1'b0;
    in_a = '0; in_b = '0; alu_done = 1'b0; alu_result = '0; alu_carry = 1'b0;
    alu_ovf = 1'b0; out_ready = 1'b0;
    e_op = '0; e_a = '0; e_b = '0;
    expect_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_alu_opcode", 32'(alu_opcode), 32'hF);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk_en = 1'b1;
    tick();

    // ADD with carry-out wrapping to zero
    run_op(OP_ADD, COND_AL, 1'b1, 32'hFFFF_FFFF, 32'h1, 3, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t1_flags", 32'(flags), 32'b0110);
    tick();
    // CMP ignores S and still writes all flags
    run_op(OP_CMP, COND_AL, 1'b0, 32'h1, 32'h2, 1, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
    chk("t2_flags", 32'(flags), 32'b1001);
    // logic op with S clears C/V
    run_op(4'h1, COND_AL, 1'b1, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1'b1, 0, 1'b0);
    chk("t3_flags", 32'(flags), 32'b0100);
    run_op(4'h2, COND_NE, 1'b1, 32'h5, 32'h6, 0, 32'h99, 1'b0, 1'b0, 0, 1'b0);
    chk("skip_ne_flags", 32'(flags), 32'b0100);
    run_op(4'h2, COND_EQ, 1'b0, 32'h5, 32'h6, 1, 32'h1234, 1'b1, 1'b1, 1, 1'b0);
    // timeout with a late completion pulse during RESP
    run_op(4'h3, COND_AL, 1'b1, 32'hA, 32'hB, -1, 32'h0, 1'b1, 1'b1, 3, 1'b1);
    chk("timeout_flags", 32'(flags), 32'b0100);
    tick();
    // done on the same edge the count expires; writeback stalled 5 cycles
    run_op(OP_ADD, COND_AL, 1'b1, 32'h7FFF_FFFE, 32'h1, TIMEOUT - 1,
           32'h7FFF_FFFF, 1'b0, 1'b1, 5, 1'b0);
    chk("boundary_flags", 32'(flags), 32'b0001);
    run_op(OP_NOP, COND_AL, 1'b1, 32'h1, 32'h1, 0, 32'h5, 1'b1, 1'b1, 0, 1'b0);
    run_op(4'h4, COND_GT, 1'b1, 32'h1, 32'h1, 0, 32'h5, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'h4, COND_LT, 1'b1, 32'h1, 32'h1, 2, 32'h8000_0000, 1'b1, 1'b1, 0, 1'b0);
    chk("lt_flags", 32'(flags), 32'b1000);
    run_op(4'h5, COND_HI, 1'b1, 32'h1, 32'h1, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'h5, COND_CS, 1'b1, 32'h1, 32'h1, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'h5, COND_NV, 1'b1, 32'h1, 32'h1, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    run_op(4'h5, COND_LS, 1'b0, 32'h3, 32'h4, 0, 32'hCAFE, 1'b1, 1'b0, 2, 1'b0);
    chk("ls_flags", 32'(flags), 32'b1000);

    // reset while waiting on the ALU
    in_valid = 1'b1; in_opcode = 4'h6; in_cond = COND_AL; in_s_bit = 1'b1;
    in_a = 32'h11; in_b = 32'h22;
    tick();
    in_valid = 1'b0; e_ready = 1'b0; e_start = 1'b1; e_op = 4'h6; e_a = 32'h11; e_b = 32'h22;
    tick();
    e_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_reset();
    chk("wrst_alu_opcode", 32'(alu_opcode), 32'hF);
    chk("wrst_flags", 32'(flags), 32'h0);
    alu_done = 1'b1; alu_result = 32'h1;
    tick();
    alu_done = 1'b0;
    tick();
    chk("wrst_no_valid", 32'(out_valid), 32'h0);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cond_sequencer.md
Name: alu_cond_sequencer

Overview:
- Sequences one instruction at a time through the shared 32-bit ALU.
- Evaluates the 4-bit condition field against the architectural NZCV register and skips the ALU when the condition fails.
- Starts the ALU and waits a variable latency for completion, then commits NZCV and hands the result to writeback over a valid/ready channel.
- Sits between decode (upstream) and the register-file write port (downstream), and owns the only NZCV register in the core.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for alu_done after alu_start before aborting. Must be ≥ 2.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  instruction offered by decode.
- in_ready  out  1  sequencer can accept an instruction.
- in_opcode  in  4  ALU opcode; 0000 = ADD, 1000 = CMP, 1111 = NOP, others = logic/move ops.
- in_cond  in  4  condition code.
- in_s_bit  in  1  set-flags request.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_opcode  out  4  latched opcode.
- alu_a  out  32  latched operand A.
- alu_b  out  32  latched operand B.
- alu_done  in  1  ALU result valid; ignored outside WAIT.
- alu_result  in  32  ALU result.
- alu_carry  in  1  ALU carry-out (ADD/CMP).
- alu_ovf  in  1  ALU signed overflow (ADD/CMP).
- out_valid  out  1  response available.
- out_ready  in  1  writeback accepts the response.
- out_result  out  32  result to write back.
- out_wr_en  out  1  response carries a register write.
- out_err  out  1  response is a timeout abort.
- flags  out  4  architectural {N,Z,C,V}.

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state=IDLE, flags=0000, in_ready=1.
  - alu_start, out_valid, out_wr_en, out_err = 0.
  - out_result, alu_a, alu_b = 0; alu_opcode=1111.
  - timeout counter = 0.
  - Reset mid-operation abandons the instruction. A late alu_done after reset is ignored because state is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, latch all inputs, evaluate the condition against the current flags, then:
    - condition fails, or opcode=1111: go to RESP with out_wr_en=0, out_result=0.
    - otherwise: go to WAIT and assert alu_start for exactly the next cycle.
  - WAIT: count cycles since alu_start.
    - On alu_done: capture alu_result, update flags per the rules below, go to RESP. out_wr_en=1 except CMP (0).
    - Timeout when the count reaches TIMEOUT with no alu_done: go to RESP with out_err=1, out_wr_en=0; flags unchanged.
  - RESP: out_valid=1; outputs held stable until out_ready. On out_valid&out_ready, go to IDLE and clear out_valid/out_err.
- in_ready is 1 only in IDLE. There is no overlap: the next accept occurs ≥1 cycle after the RESP handshake.
- Minimum latency:
  - skip/NOP: accept edge → out_valid the next cycle.
  - executed op: alu_done sampled at edge t → out_valid and new flags visible from t+1.
- Flag update, applied in the alu_done cycle only:
  - CMP: all four flags always written: N=result[31], Z=(result==0), C=alu_carry, V=alu_ovf. in_s_bit is ignored.
  - ADD with S=1: the same as CMP, plus the result is written back.
  - Any other executed op with S=1: N and Z as above; C=0, V=0.
  - S=0 (non-CMP), NOP, skipped instruction, or timeout: flags hold.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- alu_done in the same cycle as the timeout count reaching TIMEOUT: done wins; the result is committed normally.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD, OP_CMP, OP_NOP;
  - condition constants COND_EQ…COND_NV;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the state enum.
- One sub-module, cond_eval: combinational, takes (cond, flags) and returns pass. It is reused by the branch unit.

Test Plan:
- Reset, then ADD cond=AL S=1, a=0xFFFFFFFF, b=1, ALU returns result 0, carry=1, ovf=0 after 3 cycles → out_result=0, out_wr_en=1, flags=0110.
- CMP cond=AL S=0, ALU returns result 0x80000000, carry=0, ovf=1 → flags=1001, out_wr_en=0.
- With flags=0100, instruction cond=NE → no alu_start, out_valid the cycle after accept, out_wr_en=0, flags unchanged.
- Executed op, alu_done never asserted, TIMEOUT=16 → out_err=1 sixteen cycles after alu_start, flags unchanged. A later alu_done is ignored.
- out_ready held low 5 cycles in RESP → out_valid and all outputs stable, in_ready=0. Handshake → IDLE next cycle.
- rst_n low while in WAIT → next cycle IDLE, flags=0000, alu_done pulse afterward produces no out_valid.
